ks_data_path_gen: RTL and testbench

// - Parametrised K&S processor data path: IR, PC, register file, 4-op ALU (ADD/SUB/AND/OR), flag register, decoder.
// - Sits between the K&S control unit (control inputs, decoded_instruction/flags outputs) and the unified RAM (ram_addr/data_in/data_out).
// - Generalises data width and address width; adds synchronous reset of all state, SUB, and registered flags.

---
 rtl/ks_data_path_gen_if.sv | 34 +++
 rtl/ks_data_path_gen.sv | 153 +++++++++++++++
 tb/tb_ks_data_path_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_data_path_gen_if.sv
// K&S shared types and the RAM-side bus of the data path.
// The package holds the decoder output type used by both the data path and the control unit.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BOV,
        I_BNOV,
        I_BNNEG,
        I_BNZERO,
        I_HALT
    } decoded_instruction_type;
endpackage

interface ks_data_path_gen_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;

    modport master (output ram_addr, output data_out, input data_in);
    modport slave  (input ram_addr, input data_out, output data_in);
endinterface

// File: rtl/ks_data_path_gen.sv
// K&S data path: IR, PC, 4-entry register file, ADD/SUB/AND/OR ALU, registered flags and decoder.
// Optional macro KS_R0_ZERO_EN hard-wires register 0 to zero.
module ks_data_path_gen
    import k_and_s_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    ks_data_path_gen_if.master      ram
);

`ifdef KS_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam int unsigned MSB = DATA_W - 1;

    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [NREGS];

    logic [1:0]        a_addr, b_addr, c_addr;
    logic [ADDR_W-1:0] mem;
    logic [DATA_W-1:0] bus_a, bus_b, bus_c;

    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_r;
    logic              alu_z, alu_n, alu_u, alu_s;

    logic unused_ir_bit;
    assign unused_ir_bit = ir[7];

    assign mem = ir[ADDR_W-1:0];

    always_comb begin
        decoded_instruction = I_NOP;
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        case (ir[15:8])
            8'h81: begin decoded_instruction = I_LOAD;  c_addr = ir[6:5]; end
            8'h82: begin decoded_instruction = I_STORE; a_addr = ir[6:5]; end
            8'h91: begin
                decoded_instruction = I_MOVE;
                c_addr = ir[3:2];
                a_addr = ir[1:0];
                b_addr = ir[1:0];
            end
            8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                case (ir[10:8])
                    3'd1:    decoded_instruction = I_ADD;
                    3'd2:    decoded_instruction = I_SUB;
                    3'd3:    decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                c_addr = ir[5:4];
                a_addr = ir[3:2];
                b_addr = ir[1:0];
            end
            8'h01: decoded_instruction = I_BRANCH;
            8'h02: decoded_instruction = I_BZERO;
            8'h03: decoded_instruction = I_BNEG;
            8'h05: decoded_instruction = I_BOV;
            8'h06: decoded_instruction = I_BNOV;
            8'h0A: decoded_instruction = I_BNNEG;
            8'h0B: decoded_instruction = I_BNZERO;
            8'hFF: decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // Reads see the pre-edge contents, so a same-register write returns the old value.
    assign bus_a = (R0_ZERO && a_addr == 2'd0) ? '0 : regs[a_addr];
    assign bus_b = (R0_ZERO && b_addr == 2'd0) ? '0 : regs[b_addr];
    assign bus_c = c_sel ? alu_r : ram.data_in;

    assign ram.data_out = bus_a;
    assign ram.ram_addr = addr_sel ? mem : pc;

    always_comb begin
        sum   = {1'b0, bus_a} + {1'b0, bus_b};
        diff  = {1'b0, bus_a} - {1'b0, bus_b};
        alu_r = '0;
        alu_u = 1'b0;
        alu_s = 1'b0;
        case (operation)
            2'b00: begin
                alu_r = sum[DATA_W-1:0];
                alu_u = sum[DATA_W];
                alu_s = (bus_a[MSB] == bus_b[MSB]) && (alu_r[MSB] != bus_a[MSB]);
            end
            2'b01: alu_r = bus_a & bus_b;
            2'b10: alu_r = bus_a | bus_b;
            default: begin
                // The extra top bit of the widened difference is the borrow (a < b unsigned).
                alu_r = diff[DATA_W-1:0];
                alu_u = diff[DATA_W];
                alu_s = (bus_a[MSB] != bus_b[MSB]) && (alu_r[MSB] != bus_a[MSB]);
            end
        endcase
        alu_z = (alu_r == '0);
        alu_n = alu_r[MSB];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc                <= '0;
            ir                <= '0;
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (pc_enable) begin
                pc <= branch ? mem : pc + ADDR_W'(1);
            end
            if (ir_enable) begin
                ir <= ram.data_in[15:0];
            end
            if (write_reg_enable && !(R0_ZERO && c_addr == 2'd0)) begin
                regs[c_addr] <= bus_c;
            end
            if (flags_reg_enable) begin
                zero_op           <= alu_z;
                neg_op            <= alu_n;
                unsigned_overflow <= alu_u;
                signed_overflow   <= alu_s;
            end
        end
    end

endmodule

// File: tb/tb_ks_data_path_gen.sv
// Directed bench for ks_data_path_gen (DATA_W=16, ADDR_W=5): decode table, ALU table and hand sequences.
module tb_ks_data_path_gen;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n, branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic write_reg_enable, flags_reg_enable;
    logic [1:0] operation;
    decoded_instruction_type dec;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;

    int n_checks = 0;
    int n_fail = 0;

    ks_data_path_gen_if #(.DATA_W(16), .ADDR_W(5)) ram_bus ();

    ks_data_path_gen #(.DATA_W(16), .ADDR_W(5), .NREGS(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch             (branch),
        .pc_enable          (pc_enable),
        .ir_enable          (ir_enable),
        .addr_sel           (addr_sel),
        .c_sel              (c_sel),
        .operation          (operation),
        .write_reg_enable   (write_reg_enable),
        .flags_reg_enable   (flags_reg_enable),
        .decoded_instruction(dec),
        .zero_op            (zero_op),
        .neg_op             (neg_op),
        .unsigned_overflow  (unsigned_overflow),
        .signed_overflow    (signed_overflow),
        .ram                (ram_bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]             ir;
        decoded_instruction_type exp;
        logic [4:0]              mem;
    } dec_vec_t;

    typedef struct {
        logic [7:0]  opc;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flags;   // {zero, neg, uovf, sovf}
    } alu_vec_t;

    dec_vec_t dvec [19];
    alu_vec_t avec [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] w);
        ram_bus.data_in = w;
        ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8100 | (16'(r) << 5));
        ram_bus.data_in = v;
        c_sel = 1'b0;
        write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
        load_ir(16'h8200 | (16'(r) << 5));
        v = ram_bus.data_out;
    endtask

    // ALU op with c=r3, a=r1, b=r2
    task automatic alu(input logic [7:0] opc, input logic [1:0] op, input logic fen);
        load_ir({opc, 8'h36});
        operation = op;
        c_sel = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = fen;
        tick();
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] v;

        dvec[0]  = '{16'h8125, I_LOAD,   5'h05};
        dvec[1]  = '{16'h8240, I_STORE,  5'h00};
        dvec[2]  = '{16'h9107, I_MOVE,   5'h07};
        dvec[3]  = '{16'hA11B, I_ADD,    5'h1B};
        dvec[4]  = '{16'hA200, I_SUB,    5'h00};
        dvec[5]  = '{16'hA3FF, I_AND,    5'h1F};
        dvec[6]  = '{16'hA401, I_OR,     5'h01};
        dvec[7]  = '{16'h0113, I_BRANCH, 5'h13};
        dvec[8]  = '{16'h0202, I_BZERO,  5'h02};
        dvec[9]  = '{16'h0303, I_BNEG,   5'h03};
        dvec[10] = '{16'h0504, I_BOV,    5'h04};
        dvec[11] = '{16'h0605, I_BNOV,   5'h05};
        dvec[12] = '{16'h0A06, I_BNNEG,  5'h06};
        dvec[13] = '{16'h0B07, I_BNZERO, 5'h07};
        dvec[14] = '{16'hFF1F, I_HALT,   5'h1F};
        dvec[15] = '{16'h4700, I_NOP,    5'h00};
        dvec[16] = '{16'h0400, I_NOP,    5'h00};
        dvec[17] = '{16'hA500, I_NOP,    5'h00};
        dvec[18] = '{16'h8000, I_NOP,    5'h00};

        avec[0] = '{8'hA1, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
        avec[1] = '{8'hA1, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        avec[2] = '{8'hA2, 2'b11, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110};
        avec[3] = '{8'hA2, 2'b11, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
        avec[4] = '{8'hA3, 2'b01, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100};
        avec[5] = '{8'hA4, 2'b10, 16'h0F0F, 16'h00F0, 16'h0FFF, 4'b0000};
        avec[6] = '{8'hA1, 2'b00, 16'h7FFF, 16'h7FFF, 16'hFFFE, 4'b0101};
        avec[7] = '{8'hA1, 2'b00, 16'h8000, 16'h8000, 16'h0000, 4'b1011};
        avec[8] = '{8'hA2, 2'b11, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b0111};
        avec[9] = '{8'hA2, 2'b11, 16'h1234, 16'h1234, 16'h0000, 4'b1000};

        rst_n = 1'b0; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0;
        addr_sel = 1'b0; c_sel = 1'b0; operation = 2'b00;
        write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
        ram_bus.data_in = '0;
        tick();
        tick();
        rst_n = 1'b1;

        check("reset_dec", dec, I_NOP);
        check("reset_ram_addr", ram_bus.ram_addr, 5'd0);
        check("reset_data_out", ram_bus.data_out, 16'h0000);
        check("reset_flags", flags(), 4'b0000);

        // Arbitrary activity, then reset asserted mid-instruction with every enable high.
        write_reg(2'd1, 16'hFFFF);
        write_reg(2'd2, 16'h0001);
        alu(8'hA1, 2'b00, 1'b1);
        pc_enable = 1'b1;
        tick();
        tick();
        pc_enable = 1'b0;
        check("pre_reset_flags", flags(), 4'b1010);
        ram_bus.data_in = 16'hA136;
        rst_n = 1'b0;
        ir_enable = 1'b1; pc_enable = 1'b1; write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1; c_sel = 1'b1;
        tick();
        rst_n = 1'b1;
        ir_enable = 1'b0; pc_enable = 1'b0; write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
        check("rst2_dec", dec, I_NOP);
        check("rst2_pc", ram_bus.ram_addr, 5'd0);
        check("rst2_flags", flags(), 4'b0000);
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), v);
            check($sformatf("rst2_r%0d", r), v, 16'h0000);
        end

        // Decode table
        for (int i = 0; i < 19; i++) begin
            load_ir(dvec[i].ir);
            addr_sel = 1'b1;
            #1;
            check($sformatf("dec_%h", dvec[i].ir), dec, dvec[i].exp);
            check($sformatf("mem_%h", dvec[i].ir), ram_bus.ram_addr, dvec[i].mem);
            addr_sel = 1'b0;
        end

        // ALU table
        for (int i = 0; i < 10; i++) begin
            write_reg(2'd1, avec[i].a);
            write_reg(2'd2, avec[i].b);
            alu(avec[i].opc, avec[i].op, 1'b1);
            check($sformatf("alu%0d_flags", i), flags(), avec[i].flags);
            read_reg(2'd3, v);
            check($sformatf("alu%0d_res", i), v, avec[i].res);
        end

        // Flags hold without flags_reg_enable (r1=r2=0x1234 -> ADD = 0x2468)
        alu(8'hA1, 2'b00, 1'b0);
        check("flags_hold", flags(), 4'b1000);
        read_reg(2'd3, v);
        check("add_noflags_res", v, 16'h2468);

        // Read-during-write via MOVE r1 <- r1
        write_reg(2'd1, 16'h1111);
        load_ir(16'h9105);
        check("move_dec", dec, I_MOVE);
        check("move_bus_a", ram_bus.data_out, 16'h1111);
        ram_bus.data_in = 16'h2222;
        c_sel = 1'b0;
        write_reg_enable = 1'b1;
        #1;
        check("rdw_old", ram_bus.data_out, 16'h1111);
        tick();
        write_reg_enable = 1'b0;
        check("rdw_new", ram_bus.data_out, 16'h2222);

        // IR load latency, LOAD addressing and data_in write
        ram_bus.data_in = 16'h8125;
        ir_enable = 1'b1;
        #1;
        check("ir_latency_old", dec, I_MOVE);
        tick();
        ir_enable = 1'b0;
        check("ir_latency_new", dec, I_LOAD);
        addr_sel = 1'b1;
        #1;
        check("load_ram_addr", ram_bus.ram_addr, 5'd5);
        addr_sel = 1'b0;
        ram_bus.data_in = 16'hBEEF;
        c_sel = 1'b0;
        write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
        read_reg(2'd1, v);
        check("load_r1", v, 16'hBEEF);

        // PC increment, branch, wrap and same-edge IR/branch
        pc_enable = 1'b1;
        tick(); tick(); tick();
        pc_enable = 1'b0;
        check("pc_inc", ram_bus.ram_addr, 5'd3);
        load_ir(16'h0113);
        pc_enable = 1'b1; branch = 1'b1;
        tick();
        pc_enable = 1'b0; branch = 1'b0;
        check("pc_branch", ram_bus.ram_addr, 5'h13);
        load_ir(16'h011F);
        pc_enable = 1'b1; branch = 1'b1;
        tick();
        branch = 1'b0;
        check("pc_31", ram_bus.ram_addr, 5'h1F);
        tick();
        pc_enable = 1'b0;
        check("pc_wrap", ram_bus.ram_addr, 5'h00);
        load_ir(16'h0105);
        ram_bus.data_in = 16'h010A;
        ir_enable = 1'b1; pc_enable = 1'b1; branch = 1'b1;
        tick();
        ir_enable = 1'b0; pc_enable = 1'b0; branch = 1'b0;
        check("same_edge_pc_old_mem", ram_bus.ram_addr, 5'h05);
        addr_sel = 1'b1;
        #1;
        check("same_edge_new_mem", ram_bus.ram_addr, 5'h0A);
        addr_sel = 1'b0;

        // Register 0 behaviour
        write_reg(2'd0, 16'h1234);
        read_reg(2'd0, v);
`ifdef KS_R0_ZERO_EN
        check("r0_read", v, 16'h0000);
`else
        check("r0_read", v, 16'h1234);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
